// File: rtl/easyaxi_ar_mux_pkg.sv
// Shared definitions for the EASYAXI AR-channel mux family: widths, slot state, ARID packing.
package easyaxi_ar_mux_pkg;

   localparam int unsigned AXI_ID_WIDTH   = 4;
   localparam int unsigned AXI_ADDR_WIDTH = 32;

   typedef enum logic {
      SlotEmpty = 1'b0,
      SlotFull  = 1'b1
   } slot_state_e;

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Outgoing ARID is {master index, original ARID}; the R-path splits it the same way.
   function automatic logic [31:0] ar_id_cat(input logic [31:0] idx, input logic [31:0] id,
                                              input int unsigned id_w);
      return (idx << id_w) | id;
   endfunction

endpackage

// File: rtl/easyaxi_ar_mux_if.sv
// Bundled AR-channel lanes; N lanes share flattened ID/address vectors, lane i at [i*W +: W].
interface easyaxi_ar_mux_if #(
   parameter int unsigned N   = 1,
   parameter int unsigned IDW = 4,
   parameter int unsigned AW  = 32
);

   logic [N-1:0]     arvalid;
   logic [N-1:0]     arready;
   logic [N*IDW-1:0] arid;
   logic [N*AW-1:0]  araddr;

   modport master (output arvalid, output arid, output araddr, input  arready);
   modport slave  (input  arvalid, input  arid, input  araddr, output arready);

endinterface

// File: rtl/easyaxi_ar_mux_rr_arb.sv
// Round-robin request arbiter with one-hot and binary grant outputs.
// EASYAXI_AR_MUX_FIXED_PRIO_EN: drop the rotating pointer, lowest index always wins.
module easyaxi_ar_mux_rr_arb
   import easyaxi_ar_mux_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_advance,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_gnt_idx,
   output logic               o_gnt_valid
);

   logic [IDX_W-1:0] w_base;
   logic [IDX_W:0]   w_cand;
   logic [IDX_W-1:0] w_idx;

`ifdef EASYAXI_AR_MUX_FIXED_PRIO_EN
   logic w_unused;

   assign w_base   = '0;
   assign w_unused = ^{i_clk, i_rst_n, i_advance};
`else
   logic [IDX_W-1:0] r_ptr;

   assign w_base = r_ptr;

   // Pointer moves past the winner only when a grant is actually taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if (i_advance && o_gnt_valid) begin
         r_ptr <= (o_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_gnt_idx + 1'b1;
      end
   end
`endif

   always_comb begin
      o_gnt       = '0;
      o_gnt_idx   = '0;
      o_gnt_valid = 1'b0;
      w_cand      = '0;
      w_idx       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_cand = {1'b0, w_base} + (IDX_W + 1)'(k);
         if (w_cand >= (IDX_W + 1)'(NUM_REQ)) begin
            w_cand = w_cand - (IDX_W + 1)'(NUM_REQ);
         end
         w_idx = w_cand[IDX_W-1:0];
         if (!o_gnt_valid && i_req[w_idx]) begin
            o_gnt_valid  = 1'b1;
            o_gnt_idx    = w_idx;
            o_gnt[w_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/easyaxi_ar_mux.sv
// N-master to 1-slave AR mux with a single registered output slot and ARID index tagging.
// EASYAXI_AR_MUX_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module easyaxi_ar_mux
   import easyaxi_ar_mux_pkg::*;
#(
   parameter int unsigned NUM_MST    = 4,
   parameter int unsigned ID_WIDTH   = AXI_ID_WIDTH,
   parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   easyaxi_ar_mux_if.slave  mst_ar,
   easyaxi_ar_mux_if.master slv_ar
);

   localparam int unsigned MST_IDX_W = idx_width(NUM_MST);
   localparam int unsigned SLV_ID_W  = MST_IDX_W + ID_WIDTH;

   logic [NUM_MST-1:0]   w_gnt;
   logic [MST_IDX_W-1:0] w_gnt_idx;
   logic                 w_gnt_valid;
   logic                 w_can_accept;
   logic                 w_accept;
   logic [ID_WIDTH-1:0]  w_sel_id;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [SLV_ID_W-1:0]  w_slot_id;

   slot_state_e           r_state;
   logic [SLV_ID_W-1:0]   r_arid;
   logic [ADDR_WIDTH-1:0] r_araddr;

   easyaxi_ar_mux_rr_arb #(
      .NUM_REQ (NUM_MST),
      .IDX_W   (MST_IDX_W)
   ) u_arb (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req       (mst_ar.arvalid),
      .i_advance   (w_accept),
      .o_gnt       (w_gnt),
      .o_gnt_idx   (w_gnt_idx),
      .o_gnt_valid (w_gnt_valid)
   );

   // Reset gates ready directly so no master sees a handshake while the slot is held in reset.
   assign w_can_accept = i_rst_n & i_enable & ((r_state == SlotEmpty) | slv_ar.arready[0]);
   assign w_accept     = w_can_accept & w_gnt_valid;
   assign mst_ar.arready = w_accept ? w_gnt : '0;

   always_comb begin
      w_sel_id   = '0;
      w_sel_addr = '0;
      for (int unsigned m = 0; m < NUM_MST; m++) begin
         if (w_gnt[m]) begin
            w_sel_id   = mst_ar.arid[m*ID_WIDTH +: ID_WIDTH];
            w_sel_addr = mst_ar.araddr[m*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   assign w_slot_id = SLV_ID_W'(ar_id_cat(32'(w_gnt_idx), 32'(w_sel_id), ID_WIDTH));

   // Accept wins over drain, so a simultaneous drain+accept simply reloads the slot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= SlotEmpty;
         r_arid   <= '0;
         r_araddr <= '0;
      end else if (w_accept) begin
         r_state  <= SlotFull;
         r_arid   <= w_slot_id;
         r_araddr <= w_sel_addr;
      end else if (slv_ar.arready[0]) begin
         r_state  <= SlotEmpty;
      end
   end

   assign slv_ar.arvalid = (r_state == SlotFull);
   assign slv_ar.arid    = r_arid;
   assign slv_ar.araddr  = r_araddr;

endmodule

// File: tb/tb_easyaxi_ar_mux.sv
// Directed self-checking bench for easyaxi_ar_mux with NUM_MST=4, ID_WIDTH=4, ADDR_WIDTH=32.
module tb_easyaxi_ar_mux;

   localparam int unsigned NUM_MST    = 4;
   localparam int unsigned ID_WIDTH   = 4;
   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned SLV_ID_W   = 6;
`ifdef EASYAXI_AR_MUX_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic enable;
   int   n_pass  = 0;
   int   n_total = 0;

   logic [3:0]  ids   [4];
   logic [31:0] addrs [4];
   logic [38:0] obs_slot;
   logic [38:0] exp_slot;

   easyaxi_ar_mux_if #(.N(NUM_MST), .IDW(ID_WIDTH), .AW(ADDR_WIDTH)) mst_ar ();
   easyaxi_ar_mux_if #(.N(1), .IDW(SLV_ID_W), .AW(ADDR_WIDTH)) slv_ar ();

   easyaxi_ar_mux #(
      .NUM_MST    (NUM_MST),
      .ID_WIDTH   (ID_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_enable (enable),
      .mst_ar   (mst_ar),
      .slv_ar   (slv_ar)
   );

   always #5 clk = ~clk;

   assign obs_slot = {slv_ar.arvalid, slv_ar.arid, slv_ar.araddr};

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b1;
      mst_ar.arvalid = '0;
      slv_ar.arready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b1;
      mst_ar.arvalid = '0;
      slv_ar.arready = 1'b0;
      @(negedge clk);
      mst_ar.arvalid = 4'b0010;
      #1;
      n_total++;
      if (mst_ar.arready !== 4'b0000)
         $display("FAIL reset_ready_gated: got %b want 0000", mst_ar.arready);
      else n_pass++;
      n_total++;
      if (obs_slot !== 39'd0) $display("FAIL reset_slot: got %h want 0", obs_slot);
      else n_pass++;
      mst_ar.arvalid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_total++;
      if (mst_ar.arready !== 4'b0000)
         $display("FAIL reset_idle_ready: got %b want 0000", mst_ar.arready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (obs_slot !== 39'd0) $display("FAIL reset_release_slot: got %h want 0", obs_slot);
      else n_pass++;
   endtask

   task automatic test_single();
      @(negedge clk);
      mst_ar.arvalid = 4'b0100;
      slv_ar.arready = 1'b1;
      #1;
      n_total++;
      if (mst_ar.arready !== 4'b0100)
         $display("FAIL single_ready: got %b want 0100", mst_ar.arready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (obs_slot !== {1'b1, 6'h25, 32'h0000_1000})
         $display("FAIL single_slot: got %h want %h", obs_slot, {1'b1, 6'h25, 32'h0000_1000});
      else n_pass++;
      mst_ar.arvalid = '0;
      #1;
      n_total++;
      if (mst_ar.arready !== 4'b0000)
         $display("FAIL single_ready_idle: got %b want 0000", mst_ar.arready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (slv_ar.arvalid !== 1'b0) $display("FAIL single_drain: got %b want 0", slv_ar.arvalid);
      else n_pass++;
   endtask

   task automatic test_rr_stream();
      int exp_g [5];
      int g;
      exp_g = '{0, 1, 2, 3, 0};
      do_reset();
      slv_ar.arready = 1'b1;
      mst_ar.arvalid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         g = FIXED ? 0 : exp_g[c];
         n_total++;
         if (mst_ar.arready !== 4'(1 << g))
            $display("FAIL rr_ready[%0d]: got %b want %b", c, mst_ar.arready, 4'(1 << g));
         else n_pass++;
         @(negedge clk);
         exp_slot = {1'b1, 2'(g), ids[g], addrs[g]};
         n_total++;
         if (obs_slot !== exp_slot)
            $display("FAIL rr_slot[%0d]: got %h want %h", c, obs_slot, exp_slot);
         else n_pass++;
      end
      mst_ar.arvalid = '0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      mst_ar.arvalid = 4'b0001;
      slv_ar.arready = 1'b1;
      @(negedge clk);
      mst_ar.arvalid = 4'b1010;
      slv_ar.arready = 1'b0;
      exp_slot = {1'b1, 2'd0, ids[0], addrs[0]};
      for (int c = 0; c < 5; c++) begin
         #1;
         n_total++;
         if (mst_ar.arready !== 4'b0000)
            $display("FAIL bp_ready[%0d]: got %b want 0000", c, mst_ar.arready);
         else n_pass++;
         n_total++;
         if (obs_slot !== exp_slot)
            $display("FAIL bp_hold[%0d]: got %h want %h", c, obs_slot, exp_slot);
         else n_pass++;
         @(negedge clk);
      end
      slv_ar.arready = 1'b1;
      #1;
      n_total++;
      if (mst_ar.arready !== 4'b0010)
         $display("FAIL bp_release_ready: got %b want 0010", mst_ar.arready);
      else n_pass++;
      @(negedge clk);
      exp_slot = {1'b1, 2'd1, ids[1], addrs[1]};
      n_total++;
      if (obs_slot !== exp_slot)
         $display("FAIL bp_reload_m1: got %h want %h", obs_slot, exp_slot);
      else n_pass++;
      mst_ar.arvalid = 4'b1000;
      #1;
      n_total++;
      if (mst_ar.arready !== 4'b1000)
         $display("FAIL bp_ready_m3: got %b want 1000", mst_ar.arready);
      else n_pass++;
      @(negedge clk);
      exp_slot = {1'b1, 2'd3, ids[3], addrs[3]};
      n_total++;
      if (obs_slot !== exp_slot)
         $display("FAIL bp_reload_m3: got %h want %h", obs_slot, exp_slot);
      else n_pass++;
      mst_ar.arvalid = '0;
      @(negedge clk);
   endtask

   task automatic test_enable();
      int g;
      do_reset();
      @(negedge clk);
      mst_ar.arvalid = 4'b0001;
      @(negedge clk);
      exp_slot = {1'b1, 2'd0, ids[0], addrs[0]};
      n_total++;
      if (obs_slot !== exp_slot) $display("FAIL en_fill: got %h want %h", obs_slot, exp_slot);
      else n_pass++;
      enable = 1'b0;
      mst_ar.arvalid = 4'b1111;
      slv_ar.arready = 1'b1;
      #1;
      n_total++;
      if (mst_ar.arready !== 4'b0000)
         $display("FAIL en_off_ready: got %b want 0000", mst_ar.arready);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (slv_ar.arvalid !== 1'b0) $display("FAIL en_off_drain: got %b want 0", slv_ar.arvalid);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({slv_ar.arvalid, mst_ar.arready} !== 5'b0)
         $display("FAIL en_off_idle: got %b want 00000", {slv_ar.arvalid, mst_ar.arready});
      else n_pass++;
      enable = 1'b1;
      g = FIXED ? 0 : 1;
      #1;
      n_total++;
      if (mst_ar.arready !== 4'(1 << g))
         $display("FAIL en_resume_ready: got %b want %b", mst_ar.arready, 4'(1 << g));
      else n_pass++;
      @(negedge clk);
      exp_slot = {1'b1, 2'(g), ids[g], addrs[g]};
      n_total++;
      if (obs_slot !== exp_slot)
         $display("FAIL en_resume_slot: got %h want %h", obs_slot, exp_slot);
      else n_pass++;
      mst_ar.arvalid = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      mst_ar.arvalid = 4'b0100;
      @(negedge clk);
      exp_slot = {1'b1, 2'd2, ids[2], addrs[2]};
      n_total++;
      if (obs_slot !== exp_slot) $display("FAIL rm_fill: got %h want %h", obs_slot, exp_slot);
      else n_pass++;
      mst_ar.arvalid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (slv_ar.arvalid !== 1'b0) $display("FAIL rm_async_drop: got %b want 0", slv_ar.arvalid);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      mst_ar.arvalid = 4'b1111;
      slv_ar.arready = 1'b1;
      #1;
      n_total++;
      if (mst_ar.arready !== 4'b0001)
         $display("FAIL rm_restart_ready: got %b want 0001", mst_ar.arready);
      else n_pass++;
      @(negedge clk);
      exp_slot = {1'b1, 2'd0, ids[0], addrs[0]};
      n_total++;
      if (obs_slot !== exp_slot)
         $display("FAIL rm_restart_slot: got %h want %h", obs_slot, exp_slot);
      else n_pass++;
      mst_ar.arvalid = '0;
      @(negedge clk);
   endtask

   initial begin
      ids   = '{4'h3, 4'h9, 4'h5, 4'hC};
      addrs = '{32'h0000_0400, 32'h0000_0800, 32'h0000_1000, 32'h0000_2000};
      for (int i = 0; i < 4; i++) begin
         mst_ar.arid[i*ID_WIDTH +: ID_WIDTH]       = ids[i];
         mst_ar.araddr[i*ADDR_WIDTH +: ADDR_WIDTH] = addrs[i];
      end
      test_reset();
      test_single();
      test_rr_stream();
      test_backpressure();
      test_enable();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/easyaxi_ar_mux.md
Name: easyaxi_ar_mux

Overview:
- Parametrised N-master to 1-slave AXI read-address (AR) channel multiplexer with a registered output stage.
- Successor to the single point-to-point master/slave AR link; sits between NUM_MST EASYAXI masters and one EASYAXI slave.
- Arbitrates round-robin (default) among the masters' AR requests.
- Appends the winning master index to ARID so the R-path can route responses back.

Parameters:
- NUM_MST, 4, number of master ports; legal range 2..16.
- ID_WIDTH, 4, per-master ARID width.
- ADDR_WIDTH, 32, ARADDR width.
- MST_IDX_W, clog2(NUM_MST), localparam; width of the master index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when low, no new request is accepted; a held output is still presented.
- mst_arvalid  in  NUM_MST  per-master ARVALID.
- mst_arready  out  NUM_MST  per-master ARREADY.
- mst_arid  in  NUM_MST*ID_WIDTH  flattened; master i occupies bits [i*ID_WIDTH +: ID_WIDTH].
- mst_araddr  in  NUM_MST*ADDR_WIDTH  flattened, same packing.
- slv_arvalid  out  1  ARVALID to slave.
- slv_arready  in  1  ARREADY from slave.
- slv_arid  out  MST_IDX_W+ID_WIDTH  {master index, original ARID}.
- slv_araddr  out  ADDR_WIDTH  ARADDR to slave.

Behaviour:
- Reset (async, rst_n=0):
  - slv_arvalid=0; slv_arid=0; slv_araddr=0; rr_ptr=0.
  - mst_arready=0 while reset is asserted.
- Output stage: one register slot, EMPTY/FULL (slv_arvalid is the state bit).
  - can_accept = enable & (~slv_arvalid | slv_arready).
- Arbitration (combinational):
  - Search mst_arvalid starting at index rr_ptr, ascending with wrap; the first set bit is gnt_idx.
  - No valid bit set: no grant.
- Ready:
  - mst_arready[i] = can_accept & grant_valid & (i==gnt_idx).
  - At most one bit is set (one-hot or zero).
  - Ready may depend combinationally on valid; valid never depends on ready.
- Accept (mst_arvalid[g] & mst_arready[g]) at posedge:
  - slot loads {g, mst_arid[g]} and mst_araddr[g]; slv_arvalid=1.
  - rr_ptr <= (g+1) mod NUM_MST, wrapping from NUM_MST-1 to 0.
- Drain: slv_arvalid & slv_arready with no accept in the same cycle -> slv_arvalid<=0.
- Simultaneous drain and accept: the slot reloads with the new request, slv_arvalid stays 1. This gives full throughput, one transfer per cycle.
- Stability: while slv_arvalid=1 and slv_arready=0, slv_arid and slv_araddr hold constant (AXI rule).
- Latency: an accepted request appears on the slave side the next cycle.
- rr_ptr changes only on accept; an idle cycle or enable=0 leaves it unchanged.
- enable deasserted mid-stream: the held slot still drains; no new accepts happen until enable=1.
- Reset mid-transfer: slot is discarded immediately; slv_arvalid drops asynchronously.
- Masters must hold arvalid and payload until ready. The mux does not latch unaccepted requests and may switch grant between cycles if a higher-priority master raises valid.

Optional Feature:
- Macro: EASYAXI_AR_MUX_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and the search always starts at 0.
- Undefined (default): round-robin as above.
- Port list is identical in both builds.

Decomposition:
- Shared package/define file (easyaxi_define.v) holds:
  - AXI_ID_WIDTH and AXI_ADDR_WIDTH defaults.
  - A clog2 function/macro.
  - The ARID concatenation order {idx, id}.
- One natural sub-module: easyaxi_rr_arb.
  - Parametrised NUM_REQ.
  - Inputs: req vector, advance strobe.
  - Outputs: one-hot grant, binary index, grant_valid.
  - Holds rr_ptr and the FIXED_PRIO_EN switch; reused later by the R/AW muxes.

Test Plan:
1. Reset release, all mst_arvalid=0:
   - slv_arvalid=0, mst_arready=0000, rr_ptr=0.
2. Single request, master 2 (id=0x5, addr=0x1000), slv_arready=1:
   - mst_arready=0100 in the same cycle.
   - Next cycle slv_arvalid=1, slv_arid=0x25 (idx 2, id 5), slv_araddr=0x1000.
3. All four masters valid continuously, slv_arready=1, NUM_MST=4:
   - Grants 0,1,2,3,0 on consecutive cycles; one transfer per cycle, no gaps.
   - With FIXED_PRIO_EN defined: master 0 granted every cycle.
4. Backpressure: slv_arready=0 for 5 cycles with slot full and masters 1 and 3 valid:
   - mst_arready=0000 throughout; slv_arid/slv_araddr constant.
   - On slv_arready=1, the slot drains and reloads in the same cycle.
5. enable=0 with slot full and slv_arready=1:
   - Slot drains (slv_arvalid->0); no new accepts; rr_ptr unchanged.
   - enable=1 resumes acceptance with the next master in rotation.
6. rst_n asserted while slv_arvalid=1 and slv_arready=0:
   - slv_arvalid=0 immediately (asynchronous); after release, arbitration restarts at master 0.
